// File: rtl/reg_file_if.sv
// Bus bundle for reg_file: write port, two read ports and clear handshake.
// The master drives requests and the slave returns read data and status.
interface reg_file_if;
    logic        wr_en;
    logic [31:0] wr_sel;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        clr_req;
    logic        busy;
    logic        clr_done;
    logic        wr_err;

    modport master (
        output wr_en, wr_sel, wr_data, rd_addr1, rd_addr2, clr_req,
        input  rd_data1, rd_data2, busy, clr_done, wr_err
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, rd_addr1, rd_addr2, clr_req,
        output rd_data1, rd_data2, busy, clr_done, wr_err
    );
endinterface

// File: rtl/reg_file.sv
// 32x32 register file with a one-hot write port, two bypassed combinational read
// ports, and a sequential clear engine that zeroes r1..r31 one per cycle.
module reg_file (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        wr_err_q, wr_err_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic sel_onehot;
    logic busy;
    logic wr_accept;

    assign sel_onehot = (bus.wr_sel != 32'd0) && ((bus.wr_sel & (bus.wr_sel - 32'd1)) == 32'd0);
    assign busy       = (state_q != StIdle);
    assign wr_accept  = bus.wr_en & ~busy & sel_onehot & ~rst;
    assign wr_err_d   = bus.wr_en & ~rst & (busy | ~sel_onehot);

    assign bus.busy     = busy;
    assign bus.clr_done = (state_q == StDone);
    assign bus.wr_err   = wr_err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    cnt_d   = 5'd1;
                end
            end
            StClear: begin
                // Counter stops at 31; the last zeroing cycle hands off to DONE.
                if (cnt_q == 5'd31) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = 5'd0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 5'd0;
            end
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < 32; i++) begin
            if (wr_accept && bus.wr_sel[i]) begin
                regs_d[i] = bus.wr_data;
            end
        end
        if (state_q == StClear) begin
            regs_d[cnt_q] = 32'd0;
        end
        regs_d[0] = 32'd0;
    end

    // Bypass: a write accepted this cycle is visible on the read port immediately.
    function automatic logic [31:0] rd_port(input logic [4:0] addr);
        if (addr == 5'd0) begin
            return 32'd0;
        end else if (wr_accept && bus.wr_sel[addr]) begin
            return bus.wr_data;
        end else begin
            return regs_q[addr];
        end
    endfunction

    always_comb begin
        bus.rd_data1 = rd_port(bus.rd_addr1);
        bus.rd_data2 = rd_port(bus.rd_addr2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            wr_err_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_err_q <= wr_err_d;
            regs_q   <= regs_d;
        end
    end
endmodule
